// File: rtl/handshake_v1r1.sv
// -----------------------------------------------------------------------------
// handshake_v1r1
//   Registered valid/ready pipeline stage built as a 2-entry skid buffer.
//   The valid path (producer -> consumer) and the ready path (consumer ->
//   producer) are both cut by flops. The stage sustains one transfer per cycle
//   and keeps words in strict FIFO order.
//
// Optional feature macro: HANDSHAKE_V1R1_COUNT_EN
//   When defined, the COUNT_BITS parameter and the o_count port exist. o_count
//   counts downstream transfers and wraps modulo 2^COUNT_BITS. When the macro
//   is undefined, the parameter, the port and the counter are all absent.
//
// Parameters
//   VALUE_BITS  width of the data word
//   COUNT_BITS  width of o_count (only with HANDSHAKE_V1R1_COUNT_EN)
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   i_value  in   upstream data
//   i_valid  in   upstream valid
//   o_ready  out  ready to upstream (registered)
//   o_value  out  downstream data (registered, 0 while o_valid is 0)
//   o_valid  out  downstream valid (registered)
//   i_ready  in   downstream ready
//   o_count  out  downstream transfer count (only with HANDSHAKE_V1R1_COUNT_EN)
// -----------------------------------------------------------------------------
module handshake_v1r1 #(
   parameter int VALUE_BITS = 8
`ifdef HANDSHAKE_V1R1_COUNT_EN
   ,
   parameter int COUNT_BITS = 16
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [VALUE_BITS-1:0] i_value,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [VALUE_BITS-1:0] o_value,
   output logic                  o_valid,
   input  logic                  i_ready
`ifdef HANDSHAKE_V1R1_COUNT_EN
   ,
   output logic [COUNT_BITS-1:0] o_count
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [VALUE_BITS-1:0]   main_q;
   logic [VALUE_BITS-1:0]   main_next;
   logic [VALUE_BITS-1:0]   skid_q;
   logic [VALUE_BITS-1:0]   skid_next;
   logic                    ready_q;
   logic                    valid_q;
   logic                    in_xfer;
   logic                    out_xfer;

   // Both handshakes are qualified only by flopped outputs, so no
   // combinational path exists from i_valid to o_ready or from i_ready to o_valid.
   assign in_xfer  = i_valid & ready_q;
   assign out_xfer = valid_q & i_ready;

   assign o_ready  = ready_q;
   assign o_valid  = valid_q;
   assign o_value  = main_q;

   // Next-state and storage selection for the skid buffer.
   always_comb begin
      state_next = state;
      main_next  = main_q;
      skid_next  = skid_q;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               state_next = BUSY;
               main_next  = i_value;
            end else begin
               state_next = EMPTY;
            end
         end
         BUSY: begin
            if (in_xfer && out_xfer) begin
               state_next = BUSY;
               main_next  = i_value;
            end else if (in_xfer) begin
               // Consumer stalled: park the new word behind the one on display.
               state_next = FULL;
               skid_next  = i_value;
            end else if (out_xfer) begin
               // Clear the main register so o_value reads 0 while idle.
               state_next = EMPTY;
               main_next  = '0;
            end else begin
               state_next = BUSY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_next = BUSY;
               main_next  = skid_q;
            end else begin
               state_next = FULL;
            end
         end
         default: begin
            state_next = EMPTY;
            main_next  = '0;
            skid_next  = '0;
         end
      endcase
   end

   // State, storage and registered handshake outputs.
   // ready_q is 0 throughout reset and first rises at the edge after release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_next;
         main_q  <= main_next;
         skid_q  <= skid_next;
         ready_q <= (state_next != FULL);
         valid_q <= (state_next != EMPTY);
      end
   end

`ifdef HANDSHAKE_V1R1_COUNT_EN
   logic [COUNT_BITS-1:0] count_q;

   assign o_count = count_q;

   // Downstream transfer counter; wraps naturally at its width.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (out_xfer) begin
         count_q <= count_q + {{(COUNT_BITS-1){1'b0}}, 1'b1};
      end else begin
         count_q <= count_q;
      end
   end
`endif

endmodule

// File: tb/tb_handshake_v1r1.sv
// -----------------------------------------------------------------------------
// tb_handshake_v1r1
//   Self-checking bench for handshake_v1r1. A reference model treats the stage
//   as a 2-deep FIFO held in a queue: o_valid is "queue not empty", o_value is
//   the queue head (0 when empty) and o_ready is "fewer than two words held",
//   refreshed at each edge and forced low by reset. Directed sequences cover
//   reset, streaming, backpressure and mid-operation reset; a randomized run
//   of 1000 words exercises arbitrary valid/ready patterns.
//   With HANDSHAKE_V1R1_COUNT_EN defined the stage is built with COUNT_BITS=4
//   and o_count is checked against a modulo-16 transfer count.
// -----------------------------------------------------------------------------
module tb_handshake_v1r1;

   logic       clock;
   logic       reset;
   logic [7:0] i_value;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] o_value;
   logic       o_valid;
   logic       i_ready;
`ifdef HANDSHAKE_V1R1_COUNT_EN
   logic [3:0] o_count;
`endif

   handshake_v1r1 #(
      .VALUE_BITS(8)
`ifdef HANDSHAKE_V1R1_COUNT_EN
      ,
      .COUNT_BITS(4)
`endif
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .i_value(i_value),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_value(o_value),
      .o_valid(o_valid),
      .i_ready(i_ready)
`ifdef HANDSHAKE_V1R1_COUNT_EN
      ,
      .o_count(o_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_fails  = 0;

   // Reference model state
   logic [7:0] model_q[$];
   bit         model_ready = 1'b0;
   int         model_count = 0;
   int         delivered   = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic check_model();
      check("o_valid", {31'd0, o_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
      check("o_value", {24'd0, o_value}, (model_q.size() > 0) ? {24'd0, model_q[0]} : 32'd0);
      check("o_ready", {31'd0, o_ready}, {31'd0, model_ready});
`ifdef HANDSHAKE_V1R1_COUNT_EN
      check("o_count", {28'd0, o_count}, model_count % 16);
`endif
   endtask

   // One clock cycle: drive inputs and compare outputs at the falling edge,
   // then advance the model at the rising edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r);
      bit in_x;
      bit out_x;
      i_valid = v;
      i_value = d;
      i_ready = r;
      check_model();
      in_x  = v && model_ready;
      out_x = (model_q.size() > 0) && r;
      @(posedge clock);
      if (out_x) begin
         void'(model_q.pop_front());
         model_count++;
         delivered++;
      end
      if (in_x) model_q.push_back(d);
      model_ready = (model_q.size() < 2);
      @(negedge clock);
   endtask

   // Asynchronous reset pulse applied between edges; outputs must clear at once.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_q.delete();
      model_ready = 1'b0;
      model_count = 0;
      check("rst_o_valid", {31'd0, o_valid}, 32'd0);
      check("rst_o_value", {24'd0, o_value}, 32'd0);
      check("rst_o_ready", {31'd0, o_ready}, 32'd0);
`ifdef HANDSHAKE_V1R1_COUNT_EN
      check("rst_o_count", {28'd0, o_count}, 32'd0);
`endif
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] pend;
      int         sent;
      int         budget;
      bit         acc;
      logic       v;
      logic       r;

      reset   = 1'b1;
      i_valid = 1'b0;
      i_value = 8'h00;
      i_ready = 1'b0;
      @(negedge clock);

      // Reset: ready stays low until the first edge after release.
      do_reset();
      cycle(1'b0, 8'h00, 1'b1);
      check("ready_after_release", {31'd0, o_ready}, 32'd1);

      // Streaming 0x01..0x10 with both sides always willing.
      for (int k = 1; k <= 16; k++) begin
         cycle(1'b1, k[7:0], 1'b1);
         if (k > 1) check("stream_no_gap", {31'd0, o_valid}, 32'd1);
      end
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check("stream_drained", {31'd0, o_valid}, 32'd0);

      // Backpressure: A1 and A2 accepted, A3 held upstream.
      cycle(1'b1, 8'hA1, 1'b0);
      cycle(1'b1, 8'hA2, 1'b0);
      check("bp_full_ready", {31'd0, o_ready}, 32'd0);
      check("bp_head", {24'd0, o_value}, 32'h0000_00A1);
      cycle(1'b1, 8'hA3, 1'b0);
      cycle(1'b1, 8'hA3, 1'b0);
      check("bp_held", {24'd0, o_value}, 32'h0000_00A1);
      cycle(1'b1, 8'hA3, 1'b1);
      check("bp_second", {24'd0, o_value}, 32'h0000_00A2);
      cycle(1'b1, 8'hA3, 1'b1);
      check("bp_third", {24'd0, o_value}, 32'h0000_00A3);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);

      // Alternating i_ready with a continuous source: no output bubble.
      for (int k = 0; k < 12; k++) begin
         cycle(1'b1, 8'h30 + k[7:0], k[0]);
         if (k > 1) check("toggle_valid", {31'd0, o_valid}, 32'd1);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1);

      // Randomized valid/ready, 1000 words through the scoreboard.
      sent   = 0;
      budget = 0;
      pend   = 8'($urandom);
      while (sent < 1000 && budget < 20000) begin
         v   = 1'($urandom_range(0, 1));
         r   = 1'($urandom_range(0, 1));
         acc = v && model_ready;
         cycle(v, pend, r);
         if (acc) begin
            sent++;
            pend = 8'($urandom);
         end
         budget++;
      end
      check("random_all_sent", sent, 32'd1000);
      budget = 0;
      while (model_q.size() > 0 && budget < 10) begin
         cycle(1'b0, 8'h00, 1'b1);
         budget++;
      end
      check("random_drained", model_q.size(), 32'd0);

      // Reset mid-operation with 0x55/0x66 held.
      cycle(1'b1, 8'h55, 1'b0);
      cycle(1'b1, 8'h66, 1'b0);
      check("mid_full", {31'd0, o_ready}, 32'd0);
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1);
      check("mid_after_valid", {31'd0, o_valid}, 32'd0);

`ifdef HANDSHAKE_V1R1_COUNT_EN
      // 17 transfers on a 4-bit counter wrap to 1.
      do_reset();
      cycle(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 17; k++) cycle(1'b1, k[7:0], 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check("count_wrap", {28'd0, o_count}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
